// File: rtl/massive_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module      : massive_traffic_checker
// Description : AXI-Stream packet sink that checks word indices, packet length
//               and round-robin queue order, and keeps saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module massive_traffic_checker #(
    parameter int QUEUE_INDEX_WIDTH = 4,
    parameter int DATA_WIDTH        = 64,
    parameter int PKT_LEN_BYTES     = 64,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         clear_stats,
    input  logic [DATA_WIDTH-1:0]        s_axis_pkt_tdata,
    input  logic                         s_axis_pkt_tvalid,
    input  logic                         s_axis_pkt_tlast,
    input  logic [DATA_WIDTH/8-1:0]      s_axis_pkt_tkeep,
    output logic                         s_axis_pkt_tready,
    output logic [CNT_WIDTH-1:0]         pkt_count,
    output logic [CNT_WIDTH-1:0]         word_err_count,
    output logic [CNT_WIDTH-1:0]         len_err_count,
    output logic [CNT_WIDTH-1:0]         order_err_count,
    output logic [QUEUE_INDEX_WIDTH-1:0] last_queue_id,
    output logic                         last_queue_valid,
    output logic                         err_flag
);

    localparam int WORDS       = PKT_LEN_BYTES / (DATA_WIDTH / 8);
    localparam int QUEUE_COUNT = 2 ** QUEUE_INDEX_WIDTH;

    typedef enum logic [0:0] {
        ST_SOP  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic                           r_tready;
    logic [15:0]                    r_beat_idx;
    logic [QUEUE_INDEX_WIDTH-1:0]   r_cur_q;
    logic [CNT_WIDTH-1:0]           r_pkt_count;
    logic [CNT_WIDTH-1:0]           r_word_err_count;
    logic [CNT_WIDTH-1:0]           r_len_err_count;
    logic [CNT_WIDTH-1:0]           r_order_err_count;
    logic [QUEUE_INDEX_WIDTH-1:0]   r_last_q;
    logic                           r_last_valid;
    logic                           r_err_flag;

    logic                           w_accept;
    logic                           w_is_sop;
    logic [QUEUE_INDEX_WIDTH-1:0]   w_qid;
    logic [15:0]                    w_exp_idx;
    logic                           w_pad_err;
    logic                           w_word_err;
    logic                           w_done;
    logic [QUEUE_INDEX_WIDTH-1:0]   w_done_q;
    logic [QUEUE_INDEX_WIDTH-1:0]   w_next_q;
    logic [16:0]                    w_total;
    logic                           w_len_err;
    logic                           w_order_err;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    generate
        if (DATA_WIDTH > 16 + QUEUE_INDEX_WIDTH) begin : g_pad
            assign w_pad_err = |s_axis_pkt_tdata[DATA_WIDTH-1:16+QUEUE_INDEX_WIDTH];
        end else begin : g_no_pad
            assign w_pad_err = 1'b0;
        end
    endgenerate

    assign w_accept  = s_axis_pkt_tvalid & r_tready;
    assign w_is_sop  = (r_state == ST_SOP);
    assign w_qid     = s_axis_pkt_tdata[16 +: QUEUE_INDEX_WIDTH];
    assign w_exp_idx = w_is_sop ? 16'd0 : r_beat_idx;

    assign w_word_err = w_accept & ((s_axis_pkt_tdata[15:0] != w_exp_idx)
                                  | (!w_is_sop & (w_qid != r_cur_q))
                                  | !(&s_axis_pkt_tkeep)
                                  | w_pad_err);

    // Packet length is the pre-increment beat index plus the closing beat.
    assign w_done      = w_accept & s_axis_pkt_tlast;
    assign w_done_q    = w_is_sop ? w_qid : r_cur_q;
    assign w_total     = w_is_sop ? 17'd1 : ({1'b0, r_beat_idx} + 17'd1);
    assign w_len_err   = w_done & (w_total != 17'(WORDS));
    assign w_next_q    = r_last_q + QUEUE_INDEX_WIDTH'(1);
    assign w_order_err = w_done & r_last_valid & (w_done_q != w_next_q);

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (r_state)
                ST_SOP:  if (!s_axis_pkt_tlast) w_state_next = ST_BODY;
                ST_BODY: if (s_axis_pkt_tlast)  w_state_next = ST_SOP;
                default: w_state_next = ST_SOP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_SOP;
            r_tready   <= 1'b0;
            r_beat_idx <= 16'd0;
            r_cur_q    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_tready <= enable;
            if (w_accept) begin
                if (w_is_sop) begin
                    r_cur_q    <= w_qid;
                    r_beat_idx <= 16'd1;
                end else if (r_beat_idx != 16'hFFFF) begin
                    r_beat_idx <= r_beat_idx + 16'd1;
                end
            end
        end
    end

    // Clearing resets statistics only; the packet in flight keeps being checked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_count       <= '0;
            r_word_err_count  <= '0;
            r_len_err_count   <= '0;
            r_order_err_count <= '0;
            r_last_q          <= '0;
            r_last_valid      <= 1'b0;
            r_err_flag        <= 1'b0;
        end else begin
            if (w_done) r_last_q <= w_done_q;
            if (clear_stats) begin
                r_pkt_count       <= '0;
                r_word_err_count  <= '0;
                r_len_err_count   <= '0;
                r_order_err_count <= '0;
                r_last_valid      <= 1'b0;
                r_err_flag        <= 1'b0;
            end else begin
                if (w_done) begin
                    r_pkt_count  <= sat_inc(r_pkt_count);
                    r_last_valid <= 1'b1;
                end
                if (w_word_err)  r_word_err_count  <= sat_inc(r_word_err_count);
                if (w_len_err)   r_len_err_count   <= sat_inc(r_len_err_count);
                if (w_order_err) r_order_err_count <= sat_inc(r_order_err_count);
                if (w_word_err | w_len_err | w_order_err) r_err_flag <= 1'b1;
            end
        end
    end

    assign s_axis_pkt_tready = r_tready;
    assign pkt_count         = r_pkt_count;
    assign word_err_count    = r_word_err_count;
    assign len_err_count     = r_len_err_count;
    assign order_err_count   = r_order_err_count;
    assign last_queue_id     = r_last_q;
    assign last_queue_valid  = r_last_valid;
    assign err_flag          = r_err_flag;

endmodule
`default_nettype wire

// File: tb/tb_massive_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_massive_traffic_checker
// Description : Directed and randomised-gap bench with an expected-stats queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_massive_traffic_checker;

    localparam int QW = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clear_stats;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic [KW-1:0] tkeep;
    logic          tready;
    logic [CW-1:0] pkt_count, word_err_count, len_err_count, order_err_count;
    logic [QW-1:0] last_queue_id;
    logic          last_queue_valid;
    logic          err_flag;

    massive_traffic_checker #(
        .QUEUE_INDEX_WIDTH(QW),
        .DATA_WIDTH       (DW),
        .PKT_LEN_BYTES    (64),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .clear_stats      (clear_stats),
        .s_axis_pkt_tdata (tdata),
        .s_axis_pkt_tvalid(tvalid),
        .s_axis_pkt_tlast (tlast),
        .s_axis_pkt_tkeep (tkeep),
        .s_axis_pkt_tready(tready),
        .pkt_count        (pkt_count),
        .word_err_count   (word_err_count),
        .len_err_count    (len_err_count),
        .order_err_count  (order_err_count),
        .last_queue_id    (last_queue_id),
        .last_queue_valid (last_queue_valid),
        .err_flag         (err_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pkt;
        int word;
        int len;
        int order;
        int lastq;
        bit lastv;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   m_pkt, m_word, m_len, m_order, m_lastq;
    bit   m_lastv, m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pkt = 0; m_word = 0; m_len = 0; m_order = 0; m_lastv = 0; m_err = 0;
    endtask

    // Holds one beat until the sink accepts it; tready is registered, so the
    // value seen at the negedge is the one the next posedge uses.
    task automatic drive_beat(input logic [QW-1:0] q, input logic [15:0] idx,
                              input logic last, input bit rnd, input bit clr);
        bit acc;
        int n;
        if (rnd && $urandom_range(0, 1) == 1) begin
            tvalid = 1'b0;
            @(negedge clk);
        end
        tdata       = {{(DW-16-QW){1'b0}}, q, idx};
        tvalid      = 1'b1;
        tlast       = last;
        tkeep       = '1;
        clear_stats = clr;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            if (rnd) enable = ($urandom_range(0, 3) != 0);
            acc = tready;
            @(negedge clk);
            n++;
        end
        if (!acc) chk("beat_accept_timeout", 64'd0, 64'd1);
        tvalid      = 1'b0;
        tlast       = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic send_pkt(input int q, input int nbeats, input int bad_pos,
                            input bit rnd, input int clr_pos);
        exp_t e;
        bit   w, l, o;
        for (int p = 0; p < nbeats; p++) begin
            drive_beat(QW'(q), (p == bad_pos) ? 16'd5 : 16'(p), p == nbeats - 1, rnd, p == clr_pos);
            if (p == clr_pos) begin
                model_clear();
                chk("clear_pkt_count", 64'(pkt_count), 64'd0);
                chk("clear_err_flag", 64'(err_flag), 64'd0);
                chk("clear_last_valid", 64'(last_queue_valid), 64'd0);
            end
        end
        enable = 1'b1;
        w = (bad_pos >= 0 && bad_pos < nbeats);
        l = (nbeats != 8);
        o = m_lastv && (q != ((m_lastq + 1) % 16));
        m_pkt++;
        m_word  += int'(w);
        m_len   += int'(l);
        m_order += int'(o);
        m_lastq = q;
        m_lastv = 1'b1;
        m_err   = m_err | w | l | o;
        e = '{m_pkt, m_word, m_len, m_order, m_lastq, m_lastv, m_err};
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        repeat (2) @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pkt"}, 64'(pkt_count), 64'(e.pkt));
            chk({tag, "_word"}, 64'(word_err_count), 64'(e.word));
            chk({tag, "_len"}, 64'(len_err_count), 64'(e.len));
            chk({tag, "_order"}, 64'(order_err_count), 64'(e.order));
            chk({tag, "_lastq"}, 64'(last_queue_id), 64'(e.lastq));
            chk({tag, "_lastv"}, 64'(last_queue_valid), 64'(e.lastv));
            chk({tag, "_err"}, 64'(err_flag), 64'(e.err));
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        model_clear();
        chk("pulse_clear_pkt", 64'(pkt_count), 64'd0);
        chk("pulse_clear_err", 64'(err_flag), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_tready"}, 64'(tready), 64'd0);
        chk({tag, "_pkt"}, 64'(pkt_count), 64'd0);
        chk({tag, "_word"}, 64'(word_err_count), 64'd0);
        chk({tag, "_len"}, 64'(len_err_count), 64'd0);
        chk({tag, "_order"}, 64'(order_err_count), 64'd0);
        chk({tag, "_lastq"}, 64'(last_queue_id), 64'd0);
        chk({tag, "_lastv"}, 64'(last_queue_valid), 64'd0);
        chk({tag, "_err"}, 64'(err_flag), 64'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear_stats = 1'b0;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0; tkeep = '1;
        model_clear();
        m_lastq = 0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Nominal: queues 0..15 then wrap to 0
        for (int i = 0; i < 17; i++) begin
            send_pkt(i % 16, 8, -1, 1'b0, -1);
            check_out("nominal");
        end

        // Random gaps and enable toggling
        pulse_clear();
        for (int i = 0; i < 50; i++) begin
            send_pkt(i % 16, 8, -1, 1'b1, -1);
            check_out("random");
        end

        // Queue order 3,4,6
        pulse_clear();
        send_pkt(3, 8, -1, 1'b0, -1); check_out("order3");
        send_pkt(4, 8, -1, 1'b0, -1); check_out("order4");
        send_pkt(6, 8, -1, 1'b0, -1); check_out("order6");

        // Malformed length, then clean, then a bad word index
        pulse_clear();
        send_pkt(0, 6, -1, 1'b0, -1); check_out("short_pkt");
        send_pkt(1, 8, -1, 1'b0, -1); check_out("after_short");
        send_pkt(2, 8, 2, 1'b0, -1);  check_out("bad_word");

        // clear_stats at beat 4: packet counted, no order check against queue 5
        send_pkt(5, 8, -1, 1'b0, -1); check_out("pre_clear");
        send_pkt(9, 8, -1, 1'b0, 4);  check_out("mid_clear");

        // Reset mid-packet discards the partial packet
        for (int p = 0; p < 3; p++) drive_beat(QW'(7), 16'(p), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        m_lastq = 0;
        send_pkt(11, 8, -1, 1'b0, -1); check_out("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
